// File: rtl/cell_row_plotter.sv
// rtl/cell_row_plotter.sv - rasterises one captured grid row into CELL_PX x CELL_PX pixel writes
// Optional feature: define CELL_BORDER_EN to draw BORDER_COLOUR on each cell's right/bottom edge.
module cell_row_plotter #(
  parameter int         GRID_W        = 40,
  parameter int         GRID_H        = 30,
  parameter int         CELL_PX       = 4,
  parameter int         X_W           = 8,
  parameter int         Y_W           = 7,
  parameter logic [2:0] ALIVE_COLOUR  = 3'b000,
  parameter logic [2:0] DEAD_COLOUR   = 3'b111,
  parameter logic [2:0] BORDER_COLOUR = 3'b100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(GRID_H)-1:0] row_idx,
  input  logic [GRID_W-1:0]         row_data,
  input  logic                      plot_ready,
  output logic                      plot,
  output logic [X_W-1:0]            x_out,
  output logic [Y_W-1:0]            y_out,
  output logic [2:0]                c_out,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int RW = $clog2(GRID_H);
`ifdef CELL_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [PW-1:0]     px_q, px_d;
  logic [PW-1:0]     py_q, py_d;
  logic [GRID_W-1:0] row_q, row_d;
  logic [RW-1:0]     ridx_q, ridx_d;
  logic              shown_q, shown_d;

  logic              px_last, py_last, col_last;
  logic [CW-1:0]     cell_sel;
  logic              is_border;

  assign px_last  = (px_q == PW'(CELL_PX - 1));
  assign py_last  = (py_q == PW'(CELL_PX - 1));
  assign col_last = (col_q == CW'(GRID_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      row_q   <= '0;
      ridx_q  <= '0;
      shown_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      px_q    <= px_d;
      py_q    <= py_d;
      row_q   <= row_d;
      ridx_q  <= ridx_d;
      shown_q <= shown_d;
    end
  end

  // Counters freeze on the final pixel so the outputs keep showing it after the row.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    px_d    = px_q;
    py_d    = py_q;
    row_d   = row_q;
    ridx_d  = ridx_q;
    shown_d = shown_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = row_data;
          ridx_d  = row_idx;
          col_d   = '0;
          px_d    = '0;
          py_d    = '0;
          shown_d = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (plot_ready) begin
          if (col_last && px_last && py_last) begin
            state_d = DONE;
          end else if (px_last) begin
            px_d = '0;
            if (py_last) begin
              py_d  = '0;
              col_d = col_q + CW'(1);
            end else begin
              py_d = py_q + PW'(1);
            end
          end else begin
            px_d = px_q + PW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign plot = (state_q == DRAW);
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign x_out = X_W'(32'(col_q) * 32'(CELL_PX) + 32'(px_q));
  assign y_out = Y_W'(32'(ridx_q) * 32'(CELL_PX) + 32'(py_q));

  // Column 0 lives in the MSB of the captured row.
  assign cell_sel  = CW'(GRID_W - 1) - col_q;
  assign is_border = px_last || py_last;

  always_comb begin
    if (!shown_q)
      c_out = 3'b000;
    else if (BORDER_EN && is_border)
      c_out = BORDER_COLOUR;
    else if (row_q[cell_sel])
      c_out = ALIVE_COLOUR;
    else
      c_out = DEAD_COLOUR;
  end

endmodule

// File: tb/tb_cell_row_plotter.sv
// tb/tb_cell_row_plotter.sv - randomized self-checking bench for cell_row_plotter
module tb_cell_row_plotter;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int CP = 4;
  localparam int N  = GW * CP * CP;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    row_idx = '0;
  logic [GW-1:0] row_data = '0;
  logic          plot_ready = 1'b0;
  logic          plot, busy, done;
  logic [7:0]    x_out;
  logic [6:0]    y_out;
  logic [2:0]    c_out;

  int vectors = 0;
  int errors  = 0;
  int lat;

  cell_row_plotter dut (
    .clk(clk), .reset(reset), .start(start), .row_idx(row_idx), .row_data(row_data),
    .plot_ready(plot_ready), .plot(plot), .x_out(x_out), .y_out(y_out), .c_out(c_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_colour(input logic [GW-1:0] d, input int k);
    int col, px, py;
    col = k / (CP * CP);
    py  = (k % (CP * CP)) / CP;
    px  = k % CP;
`ifdef CELL_BORDER_EN
    if (px == CP - 1 || py == CP - 1) return 3'b100;
`endif
    return d[GW-1-col] ? 3'b000 : 3'b111;
  endfunction

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall at pixel 3,
  //       3 stray start at pixel 100, 4 reset at pixel 200
  task automatic run_row(input int r, input logic [GW-1:0] d, input int mode, output int latency);
    int  idx = 0;
    int  cyc = 0;
    int  stalls = 0;
    int  held = 0;
    bit  rdy;
    bit  pulsed = 0;
    latency = -1;
    @(negedge clk);
    row_idx = 5'(r); row_data = d; start = 1'b1; plot_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; row_data = {$urandom, $urandom}; row_idx = 5'($urandom);
    while (cyc < N + 400) begin
      cyc++;
      if (mode == 4 && idx == 200) begin
        reset = 1'b1;
        #1;
        check_val("abort_plot", plot, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_xyc", {x_out, y_out, c_out}, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      check_val("plot", plot, idx < N);
      check_val("busy", busy, 1);
      check_val("done", done, idx == N);
      if (idx < N) begin
        check_val("x", x_out, (idx / (CP * CP)) * CP + idx % CP);
        check_val("y", y_out, r * CP + (idx % (CP * CP)) / CP);
        check_val("c", c_out, ref_colour(d, idx));
      end
      if (idx == N) begin
        latency = cyc;
        check_val("latency", cyc, N + 1 + stalls);
        break;
      end
      case (mode)
        1: rdy = ($urandom % 4) != 0;
        2: begin
          rdy = !(idx == 3 && held < 5);
          if (!rdy) held++;
        end
        default: rdy = 1'b1;
      endcase
      if (mode == 3 && idx == 100 && !pulsed) begin
        start = 1'b1; row_data = ~d; row_idx = 5'((r + 1) % GH); pulsed = 1;
      end else begin
        start = 1'b0;
      end
      plot_ready = rdy;
      if (rdy) idx++; else stalls++;
      @(negedge clk);
    end
    start = 1'b0;
    if (latency < 0) begin
      check_val("timeout", 1, 0);
      return;
    end
    @(negedge clk);
    check_val("post_done", done, 0);
    check_val("post_busy", busy, 0);
    check_val("post_plot", plot, 0);
    check_val("hold_x", x_out, GW * CP - 1);
    check_val("hold_y", y_out, r * CP + CP - 1);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check_val("rst_out", {plot, busy, done, x_out, y_out, c_out}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_val("idle_plot", plot, 0);
    end

    run_row(2, 40'h80_0000_0000, 0, lat);
    check_val("lat_default", lat, 641);

    run_row($urandom_range(GH - 1), {$urandom, $urandom}, 2, lat);
    check_val("lat_stall", lat, 646);

    run_row(5, {$urandom, $urandom}, 3, lat);
    check_val("lat_ignore_start", lat, 641);

    run_row(7, {$urandom, $urandom}, 4, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("abort_no_done", {done, plot, busy}, 0);
    end
    run_row(0, {$urandom, $urandom}, 0, lat);
    check_val("lat_after_abort", lat, 641);

    run_row(GH - 1, '1, 1, lat);
    run_row(0, '0, 1, lat);
    for (int i = 0; i < 4; i++)
      run_row($urandom_range(GH - 1), {$urandom, $urandom}, 1, lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/cell_row_plotter.md
# cell_row_plotter

Parametrised cell-to-pixel plotter for the Game of Life display path. On a start pulse it captures one row of the cell grid and rasterises every cell of that row into a CELL_PX × CELL_PX square of pixel writes toward the VGA adapter. Each write carries x/y/colour and a valid/ready handshake, so the adapter can stall the plotter. It replaces the fixed 4×4, single-cell datapath with a self-sequenced, full-row engine of configurable geometry and colours.

## Interface
Parameters:
- GRID_W, 40: cells per row; row_data width.
- GRID_H, 30: rows in grid; row_idx width is $clog2(GRID_H).
- CELL_PX, 4: cell edge in pixels, ≥1.
- X_W, 8: x_out width; GRID_W*CELL_PX ≤ 2^X_W required.
- Y_W, 7: y_out width; GRID_H*CELL_PX ≤ 2^Y_W required.
- ALIVE_COLOUR, 3'b000: colour for cell bit = 1.
- DEAD_COLOUR, 3'b111: colour for cell bit = 0.
- BORDER_COLOUR, 3'b100: border colour; used only with CELL_BORDER_EN.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to plot one row; sampled only in IDLE.
- row_idx  in  $clog2(GRID_H)  grid row number, captured on accept.
- row_data  in  GRID_W  cell states, MSB = column 0; captured on accept.
- plot_ready  in  1  adapter accepts the current pixel.
- plot  out  1  pixel valid.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- c_out  out  3  pixel colour.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse after the last pixel is accepted.

## Operation
- FSM states: IDLE, DRAW, DONE.
- IDLE: when start=1, latch row_data and row_idx, clear col/px/py counters, and go to DRAW. With start=0, stay in IDLE.
- DRAW: plot=1 with the current pixel on the outputs.
  - On plot && plot_ready, advance px, then py, then col in raster order within a cell and cells left to right.
  - px wraps at CELL_PX-1 and increments py. py wraps at CELL_PX-1 and increments col.
- Final pixel (col=GRID_W-1, px=py=CELL_PX-1) accepted → DONE. DONE: done=1 for one cycle, then IDLE.
- Pixel address:
  - x_out = col*CELL_PX + px.
  - y_out = row_idx*CELL_PX + py.
  - Computed at full width, then truncated to X_W/Y_W. The parameter constraints make truncation lossless.
- Colour: c_out = latched_row[GRID_W-1-col] ? ALIVE_COLOUR : DEAD_COLOUR.
- Outputs are stable while plot=1 and plot_ready=0; no pixel is skipped or repeated.
- start while busy is ignored; no queueing. start in the DONE cycle is also ignored.
- Input changes to row_data/row_idx after accept have no effect.
- Outside DRAW: plot=0, and x_out/y_out/c_out hold their last value (0 after reset).

## Timing
- Reset: state IDLE; plot, busy, done, x_out, y_out, c_out, and counters all 0. This takes effect immediately, independent of clk.
- Reset mid-row aborts the row: no done pulse, and the next start begins a fresh row.
- Start accepted at edge T → busy=1 and first pixel with plot=1 after T.
- With plot_ready held high, one pixel per cycle: N = GRID_W*CELL_PX² pixels. The last pixel is presented in cycle N after T, and done is high in cycle N+1.
- Each cycle with plot_ready=0 adds exactly one cycle of latency.
- busy falls with done's deassertion. Earliest next accept is the cycle after done.
- Default row: 640 pixels, done 641 cycles after accept (no stalls).
- CELL_PX=1: px/py stay 0; one pixel per cell.

## Configuration
- CELL_BORDER_EN defined: pixels with px==CELL_PX-1 or py==CELL_PX-1 use BORDER_COLOUR regardless of cell state, giving a one-pixel grid line on each cell's right and bottom edge. With CELL_PX=1, every pixel is border.
- CELL_BORDER_EN undefined: every pixel uses the cell colour, and BORDER_COLOUR is unused. Pixel count and timing are identical in both builds.

## Test plan
- Reset: assert reset between edges → all outputs 0 immediately; release, no start → plot stays 0 for 100 cycles.
- Defaults, row_idx=2, row_data=40'h80_0000_0000, ready=1:
  - First 16 pixels: x=0..3, y=8..11, c=000.
  - Pixel 17: x=4, y=8, c=111.
  - Last pixel: x=159, y=11.
  - done 641 cycles after accept.
- Backpressure: drop plot_ready for 5 cycles at pixel 3 → x/y/c frozen, 640 distinct pixels total, done at 646.
- Start pulsed at pixel 100 with different row_data → ignored; output still matches the first row; a start two cycles after done is accepted.
- Reset at pixel 200 → plot=0, no done pulse; a new start on row 0 gives first pixel x=0, y=0.
- CELL_BORDER_EN, row_data all ones → pixels (3,y) and (x,3) of each cell are 100; all other pixels are 000.
